// File: rtl/disp_scan_ctrl.sv
// Display scan scheduler: alternates units/tens anodes with blanking guard gaps.
// Latency: outputs are registered with state; new-state values appear on the transition edge.
// No backpressure: free-running scan; new values are shown only from the next units slot.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank the tens slot when tens is 0).
module disp_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 500
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] dato_in,
  input  logic       dato_vld,
  output logic [3:0] an_out,
  output logic [3:0] dig_out,
  output logic       blank_out,
  output logic       slot_tick
);

  localparam int MAXC = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_U   = 3'd1,
    S_GUT = 3'd2,
    S_T   = 3'd3,
    S_GTU = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_shadow;
  logic [3:0]    r_committed;
  logic [3:0]    r_an;
  logic [3:0]    r_dig;
  logic          r_blank;
  logic          r_tick;

  logic          w_chg;
  logic          w_enter_u;
  logic [3:0]    w_cm_nxt;
  logic          w_tens;
  logic [3:0]    w_units;
  logic [3:0]    w_an_nxt;
  logic [3:0]    w_dig_nxt;
  logic          w_blank_nxt;
  logic          w_tick_nxt;

  assign w_chg     = (w_nxt != r_state);
  assign w_enter_u = w_chg && (w_nxt == S_U);
  // The committed value only moves on U entry, so a frame never mixes two values.
  assign w_cm_nxt  = w_enter_u ? r_shadow : r_committed;
  assign w_tens    = (w_cm_nxt >= 4'd10);
  assign w_units   = w_tens ? (w_cm_nxt - 4'd10) : w_cm_nxt;

  // State, slot counter, data registers and registered Moore outputs.
  always_ff @(posedge reloj) begin
    if (reset) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_shadow    <= 4'd0;
      r_committed <= 4'd0;
      r_an        <= 4'b1111;
      r_dig       <= 4'd0;
      r_blank     <= 1'b1;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      if (w_chg || (r_state == S_OFF)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (dato_vld) begin
        r_shadow <= dato_in;
      end
      r_committed <= w_cm_nxt;
      r_an        <= w_an_nxt;
      r_dig       <= w_dig_nxt;
      r_blank     <= w_blank_nxt;
      r_tick      <= w_tick_nxt;
    end
  end

  // Next-state: disable wins from any state; slots and guards end on their last count.
  always_comb begin
    w_nxt = r_state;
    if (!enable) begin
      w_nxt = S_OFF;
    end else begin
      case (r_state)
        S_OFF:   w_nxt = S_U;
        S_U:     if (r_cnt == REF_LAST) w_nxt = S_GUT;
        S_GUT:   if (r_cnt == GRD_LAST) w_nxt = S_T;
        S_T:     if (r_cnt == REF_LAST) w_nxt = S_GTU;
        S_GTU:   if (r_cnt == GRD_LAST) w_nxt = S_U;
        default: w_nxt = S_OFF;
      endcase
    end
  end

  // Output decode from the next state so outputs switch on the same edge as state.
  always_comb begin
    w_an_nxt    = 4'b1111;
    w_dig_nxt   = r_dig;
    w_blank_nxt = 1'b1;
    w_tick_nxt  = w_chg && ((w_nxt == S_U) || (w_nxt == S_T));
    case (w_nxt)
      S_U: begin
        w_an_nxt    = 4'b1110;
        w_dig_nxt   = w_units;
        w_blank_nxt = 1'b0;
      end
      S_T: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (w_tens) begin
          w_an_nxt    = 4'b1101;
          w_dig_nxt   = {3'b000, w_tens};
          w_blank_nxt = 1'b0;
        end
`else
        w_an_nxt    = 4'b1101;
        w_dig_nxt   = {3'b000, w_tens};
        w_blank_nxt = 1'b0;
`endif
      end
      default: begin
        w_an_nxt    = 4'b1111;
        w_blank_nxt = 1'b1;
      end
    endcase
  end

  assign an_out    = r_an;
  assign dig_out   = r_dig;
  assign blank_out = r_blank;
  assign slot_tick = r_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl with short slots (8-cycle digit, 2-cycle guard).
// Frame position model plus hand-computed scenario checks.
// Randomized enable / load / reset traffic in the final phase.
module tb_disp_scan_ctrl;

  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = 2 * (R + G);

  logic       reloj = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] dato_in;
  logic       dato_vld;
  logic [3:0] an_out;
  logic [3:0] dig_out;
  logic       blank_out;
  logic       slot_tick;

  int n_pass  = 0;
  int n_total = 0;

  disp_scan_ctrl #(.REFRESH_DIV(R), .GUARD_CYC(G)) dut (
    .reloj     (reloj),
    .reset     (reset),
    .enable    (enable),
    .dato_in   (dato_in),
    .dato_vld  (dato_vld),
    .an_out    (an_out),
    .dig_out   (dig_out),
    .blank_out (blank_out),
    .slot_tick (slot_tick)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: position within the frame since the display was last enabled.
  bit   m_valid = 0;
  bit   m_on;
  int   m_p;
  int   m_sh, m_cm;
  int   m_an, m_dig, m_blank, m_tick;

  always @(posedge reloj) begin
    if (reset) begin
      m_valid = 1; m_on = 0; m_p = 0; m_sh = 0; m_cm = 0;
      m_an = 15; m_dig = 0; m_blank = 1; m_tick = 0;
    end else begin
      if (!enable) begin
        m_on = 0; m_an = 15; m_blank = 1; m_tick = 0;
      end else begin
        m_p  = m_on ? (m_p + 1) % FRAME : 0;
        m_on = 1;
        if (m_p == 0) m_cm = m_sh;
        m_tick = (m_p == 0 || m_p == R + G) ? 1 : 0;
        if (m_p < R) begin
          m_an = 14; m_dig = m_cm % 10; m_blank = 0;
        end else if (m_p >= R + G && m_p < 2 * R + G) begin
`ifdef LEADING_ZERO_BLANK_EN
          if (m_cm / 10 == 0) begin m_an = 15; m_blank = 1; end
          else begin m_an = 13; m_dig = m_cm / 10; m_blank = 0; end
`else
          m_an = 13; m_dig = m_cm / 10; m_blank = 0;
`endif
        end else begin
          m_an = 15; m_blank = 1;
        end
      end
      if (dato_vld) m_sh = dato_in;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge reloj) begin
    if (m_valid) begin
      chk("an_out",    int'(an_out),    m_an);
      chk("dig_out",   int'(dig_out),   m_dig);
      chk("blank_out", int'(blank_out), m_blank);
      chk("slot_tick", int'(slot_tick), m_tick);
    end
  end

  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  task automatic load(input int v);
    dato_in = 4'(v); dato_vld = 1'b1;
    step();
    dato_vld = 1'b0;
  endtask

  // Advance until the entry edge of a U slot (want_u=1) or a T slot (want_u=0).
  task automatic wait_slot(input bit want_u);
    bit found = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (slot_tick === 1'b1 && ((an_out == 4'b1110) == want_u)) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      n_total++;
      $display("FAIL wait_slot: got no slot entry within 60 cycles, expected one (want_u=%0d)", want_u);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dato_in = 4'd0; dato_vld = 1'b0;
    step(); step();
    chk("rst_an", int'(an_out), 15);
    chk("rst_dig", int'(dig_out), 0);
    chk("rst_blank", int'(blank_out), 1);
    chk("rst_tick", int'(slot_tick), 0);
    reset = 1'b0;

    // Load 7 while off, then enable: 8 cycles of units, 2 guard, tens slot.
    load(7);
    enable = 1'b1;
    step();
    chk("s1_u_an", int'(an_out), 14);
    chk("s1_u_dig", int'(dig_out), 7);
    chk("s1_u_tick", int'(slot_tick), 1);
    repeat (7) step();
    chk("s1_u_last_an", int'(an_out), 14);
    chk("s1_u_last_tick", int'(slot_tick), 0);
    step();
    chk("s1_g_an", int'(an_out), 15);
    chk("s1_g_dig_hold", int'(dig_out), 7);
    step(); step();
    chk("s1_t_tick", int'(slot_tick), 1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("s1_t_an", int'(an_out), 15);
`else
    chk("s1_t_an", int'(an_out), 13);
    chk("s1_t_dig", int'(dig_out), 0);
`endif

    // Load 13: units 3, tens 1 from the next frame.
    load(13);
    wait_slot(1'b1);
    chk("s2_u_dig", int'(dig_out), 3);
    wait_slot(1'b0);
    chk("s2_t_dig", int'(dig_out), 1);
    chk("s2_t_an", int'(an_out), 13);

    // Load during a T slot must not tear the current frame.
    load(4);
    wait_slot(1'b1);
    chk("s3_u_dig4", int'(dig_out), 4);
    wait_slot(1'b0);
    load(9);
`ifndef LEADING_ZERO_BLANK_EN
    chk("s3_t_dig_old", int'(dig_out), 0);
    chk("s3_t_an", int'(an_out), 13);
`endif
    wait_slot(1'b1);
    chk("s3_u_dig9", int'(dig_out), 9);

    // Disable in the third cycle of U, re-enable restarts a full U slot.
    step(); step();
    enable = 1'b0;
    step();
    chk("s4_off_an", int'(an_out), 15);
    chk("s4_off_blank", int'(blank_out), 1);
    enable = 1'b1;
    step();
    chk("s4_re_an", int'(an_out), 14);
    chk("s4_re_tick", int'(slot_tick), 1);
    repeat (7) step();
    chk("s4_re_last_an", int'(an_out), 14);
    step();
    chk("s4_re_guard_an", int'(an_out), 15);

    // Reset in the fifth cycle of T clears everything, including the shadow.
    wait_slot(1'b0);
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("s5_rst_an", int'(an_out), 15);
    chk("s5_rst_dig", int'(dig_out), 0);
    chk("s5_rst_blank", int'(blank_out), 1);
    reset = 1'b0;
    step();
    chk("s5_u_an", int'(an_out), 14);
    chk("s5_u_dig", int'(dig_out), 0);

    // Single-digit value: tens slot either blanked or showing 0.
    load(5);
    wait_slot(1'b1);
    chk("s6_u_dig", int'(dig_out), 5);
    wait_slot(1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("s6_t_an", int'(an_out), 15);
    chk("s6_t_blank", int'(blank_out), 1);
`else
    chk("s6_t_an", int'(an_out), 13);
    chk("s6_t_dig", int'(dig_out), 0);
`endif

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 49) != 0);
      dato_vld = ($urandom_range(0, 7) == 0);
      dato_in  = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; dato_vld = 1'b0;
    step();
    @(negedge reloj);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
